// File: rtl/iso_pkg.sv
// Shared types and constants for the DP lane scrambler: K codes, LFSR taps, FSM states.
package iso_pkg;

    localparam int unsigned SYM_W     = 8;
    localparam int unsigned LFSR_W    = 16;
    localparam int unsigned MON_CNT_W = 23;

    localparam logic [SYM_W-1:0] K_SR = 8'h1C;
    localparam logic [SYM_W-1:0] K_BS = 8'hBC;
    localparam logic [SYM_W-1:0] K_BE = 8'hFB;

    // G(X)=X^16+X^5+X^4+X^3+1: l15 feeds bit 0 via rotate, these bits get the XOR
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'h0038;

    typedef enum logic [1:0] {
        BYPASS = 2'd0,
        UNSYNC = 2'd1,
        SYNC   = 2'd2
    } scr_state_e;

    typedef struct packed {
        logic             k;
        logic [SYM_W-1:0] sym;
    } iso_sym_t;

    function automatic logic is_sr(input iso_sym_t s);
        return s.k && (s.sym == K_SR);
    endfunction

endpackage

// File: rtl/scr_lfsr_step8.sv
// Combinational eight-step Galois LFSR advance, XORing one keystream bit per data bit, LSB first.
module scr_lfsr_step8
    import iso_pkg::*;
(
    input  logic [LFSR_W-1:0] lfsr_in,
    input  logic [SYM_W-1:0]  data_in,
    output logic [LFSR_W-1:0] lfsr_out,
    output logic [SYM_W-1:0]  data_out
);

    logic [LFSR_W-1:0] w_l;

    always_comb begin
        w_l      = lfsr_in;
        data_out = data_in;
        for (int i = 0; i < int'(SYM_W); i++) begin
            data_out[i] = data_in[i] ^ w_l[LFSR_W-1];
            w_l = {w_l[LFSR_W-2:0], w_l[LFSR_W-1]} ^ (w_l[LFSR_W-1] ? LFSR_TAPS : '0);
        end
        lfsr_out = w_l;
    end

endmodule

// File: rtl/iso_scrambler.sv
// Per-lane DP scrambler: 1-clk registered path, SR-aligned LFSR, BYPASS/UNSYNC/SYNC control.
// Optional SR-period monitor enabled by defining ISO_SCR_SR_MON_EN.
module iso_scrambler
    import iso_pkg::*;
#(
    parameter logic [LFSR_W-1:0] LFSR_SEED  = 16'hFFFF,
    parameter int unsigned       SR_TIMEOUT = 4194304
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SYM_W-1:0] iso_symbols,
    input  logic             iso_control_sym_flag,
    input  logic             scr_en,
    output logic [SYM_W-1:0] scr_symbols,
    output logic             scr_control_sym_flag,
    output logic             scr_synced,
    output logic             sr_period_err
);

    scr_state_e        r_state;
    scr_state_e        w_next_state;
    logic [LFSR_W-1:0] r_lfsr;
    logic [LFSR_W-1:0] w_lfsr_d;
    logic [LFSR_W-1:0] w_lfsr_step;
    logic [SYM_W-1:0]  w_scr_data;
    iso_sym_t          w_in;
    iso_sym_t          w_out_d;
    iso_sym_t          r_out;
    logic              w_is_sr;
    logic              r_synced;

    assign w_in    = {iso_control_sym_flag, iso_symbols};
    assign w_is_sr = is_sr(w_in);

    scr_lfsr_step8 u_step (
        .lfsr_in  (r_lfsr),
        .data_in  (iso_symbols),
        .lfsr_out (w_lfsr_step),
        .data_out (w_scr_data)
    );

    // Next state, next LFSR and next output symbol; disabling always wins
    always_comb begin
        w_next_state = r_state;
        w_lfsr_d     = r_lfsr;
        w_out_d      = w_in;
        case (r_state)
            BYPASS: begin
                w_lfsr_d = LFSR_SEED;
                if (scr_en) w_next_state = UNSYNC;
            end
            UNSYNC: begin
                if (w_is_sr) begin
                    w_next_state = SYNC;
                    w_lfsr_d     = LFSR_SEED;
                end
            end
            SYNC: begin
                if (w_is_sr) begin
                    w_lfsr_d = LFSR_SEED;
                end else begin
                    w_lfsr_d = w_lfsr_step;
                    if (!w_in.k) w_out_d.sym = w_scr_data;
                end
            end
            default: w_next_state = BYPASS;
        endcase
        if (!scr_en) begin
            w_next_state = BYPASS;
            w_lfsr_d     = LFSR_SEED;
            w_out_d      = w_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= BYPASS;
            r_lfsr   <= LFSR_SEED;
            r_out    <= '0;
            r_synced <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_lfsr   <= w_lfsr_d;
            r_out    <= w_out_d;
            r_synced <= (w_next_state == SYNC);
        end
    end

    assign scr_symbols          = r_out.sym;
    assign scr_control_sym_flag = r_out.k;
    assign scr_synced           = r_synced;

`ifdef ISO_SCR_SR_MON_EN
    localparam logic [MON_CNT_W-1:0] TIMEOUT_CNT = MON_CNT_W'(SR_TIMEOUT);

    logic [MON_CNT_W-1:0] r_sr_cnt;
    logic                 r_sr_err;

    // Counter saturates at the timeout so the sticky flag cannot be missed on wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr_cnt <= '0;
            r_sr_err <= 1'b0;
        end else begin
            if (w_is_sr) begin
                r_sr_cnt <= '0;
            end else if ((r_state == SYNC) && (r_sr_cnt != TIMEOUT_CNT)) begin
                r_sr_cnt <= r_sr_cnt + MON_CNT_W'(1);
            end
            if (r_sr_cnt == TIMEOUT_CNT) r_sr_err <= 1'b1;
        end
    end

    assign sr_period_err = r_sr_err;
`else
    assign sr_period_err = 1'b0 & (SR_TIMEOUT == 0);
`endif

endmodule

// File: tb/tb_iso_scrambler.sv
// Bench for iso_scrambler: vector table, directed corner sequences, random stream vs keystream model.
module tb_iso_scrambler;

    localparam int unsigned TB_TIMEOUT = 64;
    localparam int          KS_N       = 256;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] sym;
    logic       flag;
    logic       scr_en;
    logic [7:0] o_sym;
    logic       o_k;
    logic       o_syn;
    logic       o_err;

    always #5 clk = ~clk;

    iso_scrambler #(
        .LFSR_SEED  (16'hFFFF),
        .SR_TIMEOUT (TB_TIMEOUT)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .iso_symbols          (sym),
        .iso_control_sym_flag (flag),
        .scr_en               (scr_en),
        .scr_symbols          (o_sym),
        .scr_control_sym_flag (o_k),
        .scr_synced           (o_syn),
        .sr_period_err        (o_err)
    );

    int checks = 0;
    int errors = 0;

    // Keystream byte n = LFSR output bits 8n..8n+7 after the last SR
    logic [7:0] ks [KS_N];

    typedef enum int {M_BYP, M_UNS, M_SYN} mode_t;
    mode_t      m_mode;
    int         m_n;
    logic [7:0] e_sym;
    logic       e_k;
    logic       e_syn;

    typedef struct {
        logic       en;
        logic [7:0] s;
        logic       k;
        logic [7:0] es;
        logic       ek;
        logic       esyn;
    } vec_t;
    vec_t tbl [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Polynomial view: multiply state by X modulo G, emit the overflowing bit
    task automatic gen_ks();
        logic [15:0] l;
        logic        fb;
        l = 16'hFFFF;
        for (int n = 0; n < KS_N; n++) begin
            for (int i = 0; i < 8; i++) begin
                fb       = l[15];
                ks[n][i] = fb;
                l        = {l[14:0], 1'b0} ^ (fb ? 16'h0039 : 16'h0000);
            end
        end
    endtask

    task automatic model_step(input logic en, input logic [7:0] s, input logic k);
        logic sr;
        sr    = k && (s == 8'h1C);
        e_sym = s;
        e_k   = k;
        e_syn = 1'b0;
        if (!en) begin
            m_mode = M_BYP;
        end else begin
            case (m_mode)
                M_BYP: m_mode = M_UNS;
                M_UNS: begin
                    if (sr) begin
                        m_mode = M_SYN;
                        m_n    = 0;
                        e_syn  = 1'b1;
                    end
                end
                default: begin
                    e_syn = 1'b1;
                    if (sr) begin
                        m_n = 0;
                    end else begin
                        if (!k) e_sym = s ^ ks[m_n];
                        m_n++;
                    end
                end
            endcase
        end
    endtask

    task automatic cycle(input logic en, input logic [7:0] s, input logic k);
        scr_en = en;
        sym    = s;
        flag   = k;
        @(posedge clk);
        #1;
        model_step(en, s, k);
    endtask

    task automatic cyc_chk(input string name, input logic en, input logic [7:0] s, input logic k);
        cycle(en, s, k);
        chk({name, "_sym"}, 32'(o_sym), 32'(e_sym));
        chk({name, "_k"},   32'(o_k),   32'(e_k));
        chk({name, "_syn"}, 32'(o_syn), 32'(e_syn));
    endtask

    task automatic model_reset();
        m_mode = M_BYP;
        m_n    = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] seq_exp [3];
        logic       ren;
        logic [7:0] rs;
        logic       rk;
        int         r;

        gen_ks();
        model_reset();

        // Reset holds outputs low regardless of input
        rst_n  = 1'b0;
        scr_en = 1'b0;
        sym    = 8'hA5;
        flag   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sym", 32'(o_sym), 32'h00);
        chk("rst_k",   32'(o_k),   32'h0);
        chk("rst_syn", 32'(o_syn), 32'h0);
        chk("rst_err", 32'(o_err), 32'h0);
        rst_n = 1'b1;

        tbl[0]  = '{1'b0, 8'h3C, 1'b0, 8'h3C, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 8'hBC, 1'b1, 8'hBC, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 8'h55, 1'b0, 8'h55, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 8'h66, 1'b0, 8'h66, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 8'h1C, 1'b1, 8'h1C, 1'b1, 1'b1};
        tbl[5]  = '{1'b1, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b1};
        tbl[6]  = '{1'b1, 8'h00, 1'b0, 8'h17, 1'b0, 1'b1};
        tbl[7]  = '{1'b1, 8'h00, 1'b0, 8'hC0, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 8'h00, 1'b0, 8'h14, 1'b0, 1'b1};
        tbl[9]  = '{1'b1, 8'h00, 1'b0, 8'hB2, 1'b0, 1'b1};
        tbl[10] = '{1'b1, 8'h00, 1'b0, 8'hE7, 1'b0, 1'b1};
        tbl[11] = '{1'b1, 8'h00, 1'b0, 8'h02, 1'b0, 1'b1};
        tbl[12] = '{1'b1, 8'h00, 1'b0, 8'h82, 1'b0, 1'b1};
        tbl[13] = '{1'b1, 8'hFB, 1'b1, 8'hFB, 1'b1, 1'b1};

        for (int i = 0; i < 14; i++) begin
            cycle(tbl[i].en, tbl[i].s, tbl[i].k);
            chk($sformatf("tbl%0d_sym", i), 32'(o_sym), 32'(tbl[i].es));
            chk($sformatf("tbl%0d_k", i),   32'(o_k),   32'(tbl[i].ek));
            chk($sformatf("tbl%0d_syn", i), 32'(o_syn), 32'(tbl[i].esyn));
        end
        chk("err_early", 32'(o_err), 32'h0);

        // BS mid data: unscrambled, but still consumes one keystream byte
        cyc_chk("bs_sr", 1'b1, 8'h1C, 1'b1);
        cyc_chk("bs_d0", 1'b1, 8'h00, 1'b0);
        cyc_chk("bs_d1", 1'b1, 8'h00, 1'b0);
        cyc_chk("bs_k",  1'b1, 8'hBC, 1'b1);
        cycle(1'b1, 8'h00, 1'b0);
        chk("bs_after", 32'(o_sym), 32'h14);

        // 100 data symbols then a fresh SR restarts the keystream
        for (int i = 0; i < 100; i++) cyc_chk("long", 1'b1, 8'($urandom), 1'b0);
        cyc_chk("sr2", 1'b1, 8'h1C, 1'b1);
        seq_exp[0] = 8'hFF;
        seq_exp[1] = 8'h17;
        seq_exp[2] = 8'hC0;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 8'h00, 1'b0);
            chk($sformatf("sr2_z%0d", i), 32'(o_sym), 32'(seq_exp[i]));
        end

        // Disable mid-stream, re-enable without SR stays clear until SR
        cycle(1'b0, 8'h00, 1'b0);
        chk("dis_syn", 32'(o_syn), 32'h0);
        chk("dis_sym", 32'(o_sym), 32'(e_sym));
        cycle(1'b1, 8'h00, 1'b0);
        chk("reen0_sym", 32'(o_sym), 32'h00);
        cycle(1'b1, 8'h00, 1'b0);
        chk("reen1_sym", 32'(o_sym), 32'h00);
        chk("reen1_syn", 32'(o_syn), 32'h0);
        cyc_chk("reen_sr", 1'b1, 8'h1C, 1'b1);
        cycle(1'b1, 8'h00, 1'b0);
        chk("reen_first", 32'(o_sym), 32'hFF);

        // Simultaneous SR and disable: SR forwarded, then bypass
        cyc_chk("srdis", 1'b0, 8'h1C, 1'b1);
        cyc_chk("srdis_next", 1'b0, 8'h00, 1'b0);

        // Asynchronous reset in the middle of a scrambled stream
        cyc_chk("mid_en", 1'b1, 8'h11, 1'b0);
        cyc_chk("mid_en2", 1'b1, 8'h1C, 1'b1);
        cyc_chk("mid_d", 1'b1, 8'h00, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_sym", 32'(o_sym), 32'h00);
        chk("arst_syn", 32'(o_syn), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        cyc_chk("post_rst0", 1'b1, 8'h00, 1'b0);
        cyc_chk("post_rst1", 1'b1, 8'h00, 1'b0);
        chk("post_rst_clear", 32'(o_sym), 32'h00);
        cyc_chk("post_rst_sr", 1'b1, 8'h1C, 1'b1);
        cycle(1'b1, 8'h00, 1'b0);
        chk("post_rst_first", 32'(o_sym), 32'hFF);

        // Random stream against the keystream model
        for (int i = 0; i < 400; i++) begin
            ren = ($urandom_range(0, 39) != 0);
            r   = int'($urandom_range(0, 29));
            if (r == 0 || m_n >= KS_N - 16) begin
                rs = 8'h1C;
                rk = 1'b1;
            end else if (r < 3) begin
                rs = (r == 1) ? 8'hBC : 8'hFB;
                rk = 1'b1;
            end else begin
                rs = 8'($urandom);
                rk = 1'b0;
            end
            cyc_chk("rnd", ren, rs, rk);
`ifndef ISO_SCR_SR_MON_EN
            chk("rnd_err", 32'(o_err), 32'h0);
`endif
        end

        // SR-period monitor: long run in SYNC without SR
        cyc_chk("mon_a", 1'b1, 8'h00, 1'b0);
        cyc_chk("mon_b", 1'b1, 8'h00, 1'b0);
        cyc_chk("mon_sr", 1'b1, 8'h1C, 1'b1);
        for (int i = 0; i < 70; i++) cycle(1'b1, 8'($urandom), 1'b0);
`ifdef ISO_SCR_SR_MON_EN
        chk("mon_err_set", 32'(o_err), 32'h1);
        cyc_chk("mon_sr_again", 1'b1, 8'h1C, 1'b1);
        cycle(1'b1, 8'h00, 1'b0);
        chk("mon_err_sticky", 32'(o_err), 32'h1);
`else
        chk("mon_err_off", 32'(o_err), 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
